// File: rtl/cpu_boot_ctrl.sv
// Boot/load/run sequencer for the 8-bit multi-cycle core: streams an image into program memory,
// then gates the core's reset and clock enable. Define BOOT_BREAKPOINT_EN for the PC breakpoint.
module cpu_boot_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              pgm_we,
  output logic [ADDR_W-1:0] pgm_waddr,
  output logic [7:0]        pgm_wdata,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              cpu_rst,
  output logic              cpu_clk_en,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd2,
    StHalt = 3'd3,
    StStep = 3'd4
  } state_e;

  localparam logic [ADDR_W:0] LastPtr = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q;
  logic                cpu_rst_q;
  logic                en_q;
  logic                load_ready_q;
  logic                pgm_we_q;
  logic [ADDR_W-1:0]   pgm_waddr_q;
  logic [7:0]          pgm_wdata_q;
  logic [ADDR_W:0]     load_count_q;
  logic                load_err_q;
  logic [CNT_W-1:0]    run_cycles_q;
  logic                accept;
  logic                bp_stop;

  assign accept = load_valid & load_ready_q;

`ifdef BOOT_BREAKPOINT_EN
  logic armed_q;
  logic bp_hit_q;

  assign bp_stop = (state_q == StRun) & bp_valid & armed_q & (cpu_pc == bp_addr);
  assign bp_hit  = bp_hit_q;

  // Held low outside RUN/STEP so every entry starts disarmed; arms once the PC leaves bp_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else if (state_q != StRun && state_q != StStep) begin
      armed_q <= 1'b0;
    end else if (cpu_pc != bp_addr) begin
      armed_q <= 1'b1;
    end
  end
`else
  logic unused_bp;

  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{bp_addr, bp_valid, cpu_pc};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cpu_rst_q    <= 1'b0;
      en_q         <= 1'b0;
      load_ready_q <= 1'b0;
      pgm_we_q     <= 1'b0;
      pgm_waddr_q  <= '0;
      pgm_wdata_q  <= '0;
      load_count_q <= '0;
      load_err_q   <= 1'b0;
      run_cycles_q <= '0;
`ifdef BOOT_BREAKPOINT_EN
      bp_hit_q     <= 1'b0;
`endif
    end else begin
      pgm_we_q <= 1'b0;
      if (cpu_clk_en && run_cycles_q != '1) begin
        run_cycles_q <= run_cycles_q + 1'b1;
      end

      if (start_load) begin
        // Load wins over everything and may abort an accept arriving in the same cycle.
        state_q      <= StLoad;
        cpu_rst_q    <= 1'b0;
        en_q         <= 1'b0;
        load_ready_q <= 1'b1;
        load_count_q <= '0;
        load_err_q   <= 1'b0;
        run_cycles_q <= '0;
`ifdef BOOT_BREAKPOINT_EN
        bp_hit_q     <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (run_req) begin
              state_q   <= StRun;
              cpu_rst_q <= 1'b1;
              en_q      <= 1'b1;
`ifdef BOOT_BREAKPOINT_EN
              bp_hit_q  <= 1'b0;
`endif
            end
          end
          StLoad: begin
            if (accept) begin
              pgm_we_q     <= 1'b1;
              pgm_waddr_q  <= load_count_q[ADDR_W-1:0];
              pgm_wdata_q  <= load_data;
              load_count_q <= load_count_q + 1'b1;
              if (load_last || load_count_q == LastPtr) begin
                state_q      <= StIdle;
                load_ready_q <= 1'b0;
                load_err_q   <= ~load_last;
              end
            end
          end
          StRun: begin
            if (halt_req || bp_stop) begin
              state_q  <= StHalt;
              en_q     <= 1'b0;
`ifdef BOOT_BREAKPOINT_EN
              bp_hit_q <= bp_stop;
`endif
            end
          end
          StHalt: begin
            if (!halt_req) begin
              if (run_req) begin
                state_q  <= StRun;
                en_q     <= 1'b1;
`ifdef BOOT_BREAKPOINT_EN
                bp_hit_q <= 1'b0;
`endif
              end else if (step_req) begin
                state_q  <= StStep;
                en_q     <= 1'b1;
`ifdef BOOT_BREAKPOINT_EN
                bp_hit_q <= 1'b0;
`endif
              end
            end
          end
          StStep: begin
            state_q <= StHalt;
            en_q    <= 1'b0;
          end
          default: begin
            state_q      <= StIdle;
            cpu_rst_q    <= 1'b0;
            en_q         <= 1'b0;
            load_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cpu_clk_en = en_q & ~bp_stop;
  assign cpu_rst    = cpu_rst_q;
  assign load_ready = load_ready_q;
  assign pgm_we     = pgm_we_q;
  assign pgm_waddr  = pgm_waddr_q;
  assign pgm_wdata  = pgm_wdata_q;
  assign state      = state_q;
  assign load_count = load_count_q;
  assign load_err   = load_err_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl: vector table plus hand-written load/run/step sequences.
module tb_cpu_boot_ctrl;

  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_load, load_valid, load_last, load_ready;
  logic [7:0]    load_data;
  logic          pgm_we;
  logic [AW-1:0] pgm_waddr;
  logic [7:0]    pgm_wdata;
  logic          run_req, halt_req, step_req;
  logic [AW-1:0] bp_addr;
  logic          bp_valid;
  logic [AW-1:0] cpu_pc = '0;
  logic          cpu_rst, cpu_clk_en;
  logic [2:0]    state;
  logic [AW:0]   load_count;
  logic          load_err, bp_hit;
  logic [CW-1:0] run_cycles;

  int checks = 0;
  int errors = 0;

  cpu_boot_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .pgm_we     (pgm_we),
    .pgm_waddr  (pgm_waddr),
    .pgm_wdata  (pgm_wdata),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .cpu_pc     (cpu_pc),
    .cpu_rst    (cpu_rst),
    .cpu_clk_en (cpu_clk_en),
    .state      (state),
    .load_count (load_count),
    .load_err   (load_err),
    .bp_hit     (bp_hit),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  // Core stand-in: executes NOPs, so the PC counts enabled edges while out of reset.
  always @(posedge clk) begin
    if (cpu_rst !== 1'b1) cpu_pc <= '0;
    else if (cpu_clk_en === 1'b1) cpu_pc <= cpu_pc + 1'b1;
  end

  typedef struct {
    logic       sl, lv;
    logic [7:0] ld;
    logic       ll, rr, hr, sr;
    logic [2:0] st;
    logic       crst, en, rdy, we;
    logic [7:0] wa, wd;
    logic [8:0] cnt;
    logic       err;
    logic [15:0] rc;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    start_load = 0; load_valid = 0; load_data = 0; load_last = 0;
    run_req = 0; halt_req = 0; step_req = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " state"}, 32'(state), 0);
    check({tag, " cpu_rst"}, 32'(cpu_rst), 0);
    check({tag, " clk_en"}, 32'(cpu_clk_en), 0);
    check({tag, " ready"}, 32'(load_ready), 0);
    check({tag, " we"}, 32'(pgm_we), 0);
    check({tag, " waddr"}, 32'(pgm_waddr), 0);
    check({tag, " wdata"}, 32'(pgm_wdata), 0);
    check({tag, " count"}, 32'(load_count), 0);
    check({tag, " err"}, 32'(load_err), 0);
    check({tag, " bp_hit"}, 32'(bp_hit), 0);
    check({tag, " run_cycles"}, 32'(run_cycles), 0);
  endtask

  initial begin
    //          sl lv ld     ll rr hr sr | st crst en rdy we wa     wd     cnt err rc
    vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0};
    vecs[1]  = '{0, 1, 8'h80, 0, 0, 0, 0,  1, 0, 0, 1, 1, 8'h00, 8'h80, 1, 0, 0};
    vecs[2]  = '{0, 1, 8'h05, 0, 0, 0, 0,  1, 0, 0, 1, 1, 8'h01, 8'h05, 2, 0, 0};
    vecs[3]  = '{0, 1, 8'h70, 0, 0, 0, 0,  1, 0, 0, 1, 1, 8'h02, 8'h70, 3, 0, 0};
    vecs[4]  = '{0, 1, 8'h70, 1, 0, 0, 0,  0, 0, 0, 0, 1, 8'h03, 8'h70, 4, 0, 0};
    vecs[5]  = '{0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 8'h00, 8'h00, 4, 0, 0};
    vecs[6]  = '{0, 0, 8'h00, 0, 0, 0, 1,  0, 0, 0, 0, 0, 8'h00, 8'h00, 4, 0, 0};
    vecs[7]  = '{0, 0, 8'h00, 0, 0, 1, 0,  0, 0, 0, 0, 0, 8'h00, 8'h00, 4, 0, 0};
    vecs[8]  = '{0, 0, 8'h00, 0, 1, 0, 0,  2, 1, 1, 0, 0, 8'h00, 8'h00, 4, 0, 0};
    vecs[9]  = '{0, 0, 8'h00, 0, 0, 0, 1,  2, 1, 1, 0, 0, 8'h00, 8'h00, 4, 0, 1};
    vecs[10] = '{0, 0, 8'h00, 0, 1, 1, 0,  3, 1, 0, 0, 0, 8'h00, 8'h00, 4, 0, 2};
    vecs[11] = '{0, 0, 8'h00, 0, 0, 0, 1,  4, 1, 1, 0, 0, 8'h00, 8'h00, 4, 0, 2};
    vecs[12] = '{0, 0, 8'h00, 0, 0, 0, 0,  3, 1, 0, 0, 0, 8'h00, 8'h00, 4, 0, 3};
    vecs[13] = '{0, 0, 8'h00, 0, 1, 0, 1,  2, 1, 1, 0, 0, 8'h00, 8'h00, 4, 0, 3};
    vecs[14] = '{1, 0, 8'h00, 0, 0, 1, 0,  1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0};
    vecs[15] = '{0, 0, 8'h00, 0, 1, 0, 0,  1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0};
    vecs[16] = '{0, 1, 8'hAA, 0, 0, 0, 0,  1, 0, 0, 1, 1, 8'h00, 8'hAA, 1, 0, 0};
    vecs[17] = '{1, 1, 8'hBB, 0, 0, 0, 0,  1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0};
    vecs[18] = '{0, 1, 8'hCC, 1, 0, 0, 0,  0, 0, 0, 0, 1, 8'h00, 8'hCC, 1, 0, 0};

    clr_in();
    bp_addr = '0; bp_valid = 0;
    rst = 1;
    tick(); tick();
    check_reset_vals("reset");
    rst = 0;

    for (int i = 0; i < 19; i++) begin
      start_load = vecs[i].sl; load_valid = vecs[i].lv; load_data = vecs[i].ld;
      load_last = vecs[i].ll; run_req = vecs[i].rr; halt_req = vecs[i].hr;
      step_req = vecs[i].sr;
      tick();
      check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("v%0d cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].crst));
      check($sformatf("v%0d clk_en", i), 32'(cpu_clk_en), 32'(vecs[i].en));
      check($sformatf("v%0d ready", i), 32'(load_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d we", i), 32'(pgm_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d waddr", i), 32'(pgm_waddr), 32'(vecs[i].wa));
        check($sformatf("v%0d wdata", i), 32'(pgm_wdata), 32'(vecs[i].wd));
      end
      check($sformatf("v%0d count", i), 32'(load_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d err", i), 32'(load_err), 32'(vecs[i].err));
      check($sformatf("v%0d run_cycles", i), 32'(run_cycles), 32'(vecs[i].rc));
    end
    clr_in();

    // Overflow: 257 bytes without load_last.
    start_load = 1; tick(); clr_in();
    for (int i = 0; i < 257; i++) begin
      load_valid = 1; load_data = 8'(i);
      tick();
      if (i < 256) begin
        check($sformatf("ovf we %0d", i), 32'(pgm_we), 1);
        check($sformatf("ovf waddr %0d", i), 32'(pgm_waddr), 32'(i));
        check($sformatf("ovf wdata %0d", i), 32'(pgm_wdata), 32'(i & 255));
      end else begin
        check("ovf 257th not written", 32'(pgm_we), 0);
      end
      if (i == 255) begin
        check("ovf state", 32'(state), 0);
        check("ovf ready", 32'(load_ready), 0);
      end
    end
    clr_in();
    check("ovf err", 32'(load_err), 1);
    check("ovf count", 32'(load_count), 256);

    // Run 10 cycles, halt, then three single steps.
    start_load = 1; tick(); clr_in();
    check("rs err cleared", 32'(load_err), 0);
    load_valid = 1; load_last = 1; tick(); clr_in();
    run_req = 1; tick(); clr_in();
    check("rs cpu_rst up", 32'(cpu_rst), 1);
    repeat (9) tick();
    halt_req = 1; tick(); clr_in();
    check("rs halt state", 32'(state), 3);
    check("rs halt clk_en", 32'(cpu_clk_en), 0);
    check("rs halt cpu_rst", 32'(cpu_rst), 1);
    check("rs run_cycles 10", 32'(run_cycles), 10);
    check("rs pc 10", 32'(cpu_pc), 10);
    repeat (3) tick();
    check("rs pc frozen", 32'(cpu_pc), 10);
    for (int s = 0; s < 3; s++) begin
      step_req = 1; tick(); clr_in();
      check($sformatf("step%0d state", s), 32'(state), 4);
      check($sformatf("step%0d clk_en", s), 32'(cpu_clk_en), 1);
      tick();
      check($sformatf("step%0d back", s), 32'(state), 3);
      check($sformatf("step%0d pc", s), 32'(cpu_pc), 32'(11 + s));
    end
    check("rs run_cycles 13", 32'(run_cycles), 13);

    // start_load while running.
    run_req = 1; tick(); clr_in();
    tick(); tick();
    start_load = 1; tick(); clr_in();
    check("abort state", 32'(state), 1);
    check("abort cpu_rst", 32'(cpu_rst), 0);
    check("abort clk_en", 32'(cpu_clk_en), 0);
    check("abort run_cycles", 32'(run_cycles), 0);
    load_valid = 1; load_last = 1; tick(); clr_in();
    check("abort load done", 32'(state), 0);

    // Reset asserted mid-load.
    start_load = 1; tick(); clr_in();
    load_valid = 1; load_data = 8'h11; tick();
    load_data = 8'h22; tick();
    rst = 1; load_data = 8'h33; tick();
    check_reset_vals("midrst");
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("midrst no we %0d", k), 32'(pgm_we), 0);
      check($sformatf("midrst idle %0d", k), 32'(state), 0);
    end
    clr_in();

    bp_addr = 8'h03; bp_valid = 1;
`ifdef BOOT_BREAKPOINT_EN
    begin
      int waited;
      run_req = 1; tick(); clr_in();
      waited = 0;
      while (state != 3'd3 && waited < 30) begin
        tick();
        waited++;
      end
      check("bp reached halt", 32'(waited < 30), 1);
      check("bp pc", 32'(cpu_pc), 3);
      check("bp hit", 32'(bp_hit), 1);
      check("bp clk_en", 32'(cpu_clk_en), 0);
      run_req = 1; tick(); clr_in();
      check("bp resume state", 32'(state), 2);
      check("bp hit cleared", 32'(bp_hit), 0);
      repeat (3) tick();
      check("bp progress pc", 32'(cpu_pc), 6);
    end
`else
    run_req = 1; tick(); clr_in();
    repeat (5) tick();
    check("nobp pc passes", 32'(cpu_pc), 5);
    check("nobp hit", 32'(bp_hit), 0);
`endif
    halt_req = 1; tick(); clr_in();
    check("final halt", 32'(state), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_boot_ctrl.md
# cpu_boot_ctrl

Boot, load and run controller that sequences the 8-bit multi-cycle CPU core. It streams a program image byte-by-byte into the 256-byte program memory and holds the CPU in reset while loading. It then releases the core and gates its clock enable to support run, halt, single-step and an optional PC breakpoint. It sits at the top level between the host/debug byte stream, the program memory write port and the core's `rst`/clock-enable/`program_adress` pins.

## Interface
- `ADDR_W`, 8: program memory address width; image limit is 2^ADDR_W bytes.
- `CNT_W`, 16: width of the run-cycle counter.

- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_load`  in  1  pulse; begin a new image load (aborts run/halt).
- `load_valid`  in  1  load byte valid.
- `load_data`  in  8  load byte.
- `load_last`  in  1  qualifies the final byte of the image.
- `load_ready`  out  1  controller accepts a byte this cycle.
- `pgm_we`  out  1  program memory write strobe.
- `pgm_waddr`  out  ADDR_W  program memory write address.
- `pgm_wdata`  out  8  program memory write data.
- `run_req`, `halt_req`, `step_req`  in  1 each  control pulses.
- `bp_addr`  in  ADDR_W  breakpoint PC (macro only).
- `bp_valid`  in  1  breakpoint enable (macro only).
- `cpu_pc`  in  ADDR_W  the core's `program_adress`.
- `cpu_rst`  out  1  drives the core's active-low `rst`; 0 holds the core in reset.
- `cpu_clk_en`  out  1  core clock enable.
- `state`  out  3  IDLE=0, LOAD=1, RUN=2, HALT=3, STEP=4.
- `load_count`  out  ADDR_W+1  bytes written by the last load.
- `load_err`  out  1  sticky: image exceeded 2^ADDR_W bytes without `load_last`.
- `bp_hit`  out  1  sticky: halted by breakpoint; clears on the next RUN/STEP/LOAD.
- `run_cycles`  out  CNT_W  saturating count of cycles with `cpu_clk_en`=1; clears on load.

## Operation
- Reset values: state IDLE. `cpu_rst`=0. `cpu_clk_en`, `load_ready`, `pgm_we`=0. `pgm_waddr`, `pgm_wdata`, `load_count`, `run_cycles`=0. `load_err`, `bp_hit`=0.
- Priority for simultaneous requests: `start_load` > `halt_req` > `run_req` > `step_req`.
- IDLE:
  - Core held in reset.
  - `start_load` -> LOAD.
  - `run_req` -> RUN (runs the current memory contents).
- LOAD:
  - `cpu_rst`=0 and `load_ready`=1.
  - Entry clears the write pointer, `load_count`, `load_err` and `run_cycles`.
  - Each accept (`load_valid`&`load_ready`) writes `load_data` at the pointer, then increments the pointer and `load_count`.
  - An accept with `load_last`=1 -> IDLE.
  - An accept at pointer 2^ADDR_W-1 without `load_last` -> IDLE and sets `load_err`. The pointer never wraps.
  - `start_load` while in LOAD restarts at pointer 0.
- RUN:
  - `cpu_rst`=1 and `cpu_clk_en`=1.
  - `halt_req` -> HALT.
  - `start_load` -> LOAD, and `cpu_rst` returns to 0.
- HALT:
  - `cpu_rst`=1 and `cpu_clk_en`=0; core state is preserved.
  - `run_req` -> RUN.
  - `step_req` -> STEP.
- STEP: lasts exactly one cycle with `cpu_clk_en`=1, then -> HALT.
- `step_req` is ignored outside HALT. `run_req`/`halt_req` are ignored in LOAD.
- `run_cycles` saturates at all-ones.

## Timing
- All state and outputs are registered except the breakpoint term of `cpu_clk_en`.
- A request sampled at edge N changes `state` and the outputs at edge N (visible in cycle N+1).
- `pgm_we`/`pgm_waddr`/`pgm_wdata` appear one cycle after the accept, as a single-cycle pulse per byte. Back-to-back accepts give back-to-back writes.
- `load_ready` drops in the cycle after the terminating accept.
- IDLE->RUN: `cpu_rst` rises one cycle after `run_req`. The core's first fetch edge is the next edge.
- RUN->HALT: after `halt_req` at edge N, the core receives no enabled edge after N.
- STEP: exactly one enabled core edge per `step_req`. A multi-cycle instruction needs 2–3 steps.

## Configuration
- `BOOT_BREAKPOINT_EN` defined:
  - In RUN, `cpu_clk_en` = run_en & ~(`bp_valid` & armed & `cpu_pc`==`bp_addr`), combinationally, so the core stops with PC at `bp_addr` before that fetch edge.
  - The same cycle registers the transition to HALT and sets `bp_hit`.
  - `armed` clears on every entry to RUN or STEP and sets once `cpu_pc`≠`bp_addr`, so resuming from a breakpoint makes progress.
- `BOOT_BREAKPOINT_EN` undefined:
  - `bp_addr`/`bp_valid` are ignored.
  - `bp_hit` is tied 0.
  - `cpu_clk_en` is purely registered.

## Test plan
- Load 4 bytes 0x80,0x05,0x70,0x70 with `load_last` on the 4th -> writes at addresses 0..3 with matching data, `load_count`=4, `load_err`=0, state IDLE, `cpu_rst`=0 throughout.
- Stream 257 bytes with no `load_last` -> 256 writes (addresses 0..255), `load_err`=1, `load_count`=256, 257th byte not accepted.
- Load, then `run_req`, then `halt_req` after 10 cycles -> `cpu_rst`=1, `run_cycles`=10, PC frozen; 3 `step_req` pulses -> `run_cycles`=13, exactly 3 enabled edges.
- Same cycle `halt_req`+`run_req` in RUN -> HALT; `start_load` during RUN -> `cpu_rst`=0 next cycle, `run_cycles`=0, state LOAD.
- With `BOOT_BREAKPOINT_EN`, `bp_addr`=0x03, program NOP x6 -> halts with `cpu_pc`=0x03, `bp_hit`=1; `run_req` -> PC advances past 0x03.
- Assert `rst` mid-load -> all outputs return to reset values next cycle, no further `pgm_we`.
